// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard port bundle: operand reads, issue hazard check and writeback.
// master = decode/issue + writeback side, slave = register file.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            issue_valid;
  logic            issue_uses_rs1;
  logic            issue_uses_rs2;
  logic            issue_rd_we;
  logic [4:0]      issue_rd;
  logic            stall;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [5:0]      outstanding;
  logic            wb_err;

  modport master (
    output rs1_addr, rs2_addr, issue_valid, issue_uses_rs1, issue_uses_rs2,
           issue_rd_we, issue_rd, wb_valid, wb_rd, wb_data,
    input  rs1_data, rs2_data, stall, outstanding, wb_err
  );

  modport slave (
    input  rs1_addr, rs2_addr, issue_valid, issue_uses_rs1, issue_uses_rs2,
           issue_rd_we, issue_rd, wb_valid, wb_rd, wb_data,
    output rs1_data, rs2_data, stall, outstanding, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// RV32 integer register file with write-through read bypass and a per-register
// busy scoreboard that stalls issue on RAW/WAW hazards against pending writers.
module regfile_scoreboard #(
  parameter int XLEN = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave rf
);

  logic [XLEN-1:0] regs [1:31];
  logic [31:0]     busy_q;
  logic [5:0]      outstanding_q;
  logic            wb_err_q;

  logic            wb_commit;
  logic [31:0]     wb_hit;
  logic [31:0]     busy_eff;
  logic            hazard;
  logic            accept;
  logic [31:0]     set_vec;
  logic [31:0]     busy_nxt;
  logic            set_any;
  logic            clr_any;
  logic            spurious;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  // x0 writebacks are dropped before they reach the scoreboard or the error flag
  assign wb_commit = rf.wb_valid && (rf.wb_rd != 5'd0);
  assign wb_hit    = wb_commit ? (32'd1 << rf.wb_rd) : 32'd0;
  assign busy_eff  = busy_q & ~wb_hit;

  assign hazard = (rf.issue_uses_rs1 && busy_eff[rf.rs1_addr]) ||
                  (rf.issue_uses_rs2 && busy_eff[rf.rs2_addr]) ||
                  (rf.issue_rd_we    && busy_eff[rf.issue_rd]);
  assign accept = rf.issue_valid && !hazard;

  assign set_vec  = (accept && rf.issue_rd_we && (rf.issue_rd != 5'd0)) ?
                    (32'd1 << rf.issue_rd) : 32'd0;
  // Clear before set so a same-cycle re-issue of the written register stays busy
  assign busy_nxt = (busy_q & ~wb_hit) | set_vec;
  assign set_any  = |set_vec;
  assign clr_any  = |(busy_q & wb_hit);
  assign spurious = wb_commit && !busy_q[rf.wb_rd];

  always_comb begin
    rd1 = '0;
    if (rf.rs1_addr != 5'd0)
      rd1 = (wb_commit && (rf.wb_rd == rf.rs1_addr)) ? rf.wb_data : regs[rf.rs1_addr];
  end

  always_comb begin
    rd2 = '0;
    if (rf.rs2_addr != 5'd0)
      rd2 = (wb_commit && (rf.wb_rd == rf.rs2_addr)) ? rf.wb_data : regs[rf.rs2_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
      busy_q        <= '0;
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      if (wb_commit) regs[rf.wb_rd] <= rf.wb_data;
      busy_q        <= busy_nxt;
      outstanding_q <= outstanding_q + {5'd0, set_any} - {5'd0, clr_any};
      if (spurious) wb_err_q <= 1'b1;
    end
  end

  assign rf.rs1_data    = rd1;
  assign rf.rs2_data    = rd2;
  assign rf.stall       = rf.issue_valid && hazard;
  assign rf.outstanding = outstanding_q;
  assign rf.wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, async-reset and fill
// sequences, then random traffic against an array-based reference model.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;

  regfile_scoreboard_if #(.XLEN(32)) bus ();
  regfile_scoreboard #(.XLEN(32)) dut (.clk(clk), .rst(rst), .rf(bus));

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] mregs [32];
  bit          mbusy [32];
  bit          merr;

  typedef struct {
    logic        iv, u1, u2, we;
    logic [4:0]  rd, rs1, rs2;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        e_stall;
    logic [31:0] e_rs1, e_rs2;
    logic [5:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic iv, logic u1, logic u2, logic we, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic wv, logic [4:0] wrd,
                              logic [31:0] wdata, logic es, logic [31:0] e1, logic [31:0] e2,
                              logic [5:0] eo, logic ee);
    vec_t v;
    v.iv = iv; v.u1 = u1; v.u2 = u2; v.we = we; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.wv = wv; v.wrd = wrd; v.wdata = wdata; v.e_stall = es; v.e_rs1 = e1; v.e_rs2 = e2;
    v.e_out = eo; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic drive(input logic iv, input logic u1, input logic u2, input logic we,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic wv, input logic [4:0] wrd, input logic [31:0] wdata);
    bus.issue_valid = iv; bus.issue_uses_rs1 = u1; bus.issue_uses_rs2 = u2;
    bus.issue_rd_we = we; bus.issue_rd = rd; bus.rs1_addr = rs1; bus.rs2_addr = rs2;
    bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wdata;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin mregs[i] = '0; mbusy[i] = 0; end
    merr = 0;
  endfunction

  // A register still has a writer pending this cycle unless it is being written back now
  function automatic bit pending(input logic [4:0] r);
    if (r == 0 || !mbusy[r]) return 0;
    return !(bus.wb_valid && bus.wb_rd == r);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (bus.wb_valid && bus.wb_rd == a) return bus.wb_data;
    return mregs[a];
  endfunction

  function automatic bit model_stall();
    if (!bus.issue_valid) return 0;
    return (bus.issue_uses_rs1 && pending(bus.rs1_addr)) ||
           (bus.issue_uses_rs2 && pending(bus.rs2_addr)) ||
           (bus.issue_rd_we && pending(bus.issue_rd));
  endfunction

  function automatic int model_out();
    int c = 0;
    for (int i = 0; i < 32; i++) if (mbusy[i]) c++;
    return c;
  endfunction

  // Called just before a rising edge with inputs stable; returns at the next falling edge
  task automatic clock_and_commit();
    bit          acc  = bus.issue_valid && !model_stall();
    bit          we   = bus.issue_rd_we;
    logic [4:0]  ird  = bus.issue_rd;
    bit          wv   = bus.wb_valid && bus.wb_rd != 0;
    logic [4:0]  wrd  = bus.wb_rd;
    logic [31:0] wdat = bus.wb_data;
    @(posedge clk);
    if (wv) begin
      if (!mbusy[wrd]) merr = 1;
      mregs[wrd] = wdat;
      mbusy[wrd] = 0;
    end
    if (acc && we && ird != 0) mbusy[ird] = 1;
    @(negedge clk);
  endtask

  task automatic cycle_check(input string tag);
    #2;
    chk({tag, "_stall"}, 32'(bus.stall), 32'(model_stall()));
    chk({tag, "_rs1"}, bus.rs1_data, model_read(bus.rs1_addr));
    chk({tag, "_rs2"}, bus.rs2_data, model_read(bus.rs2_addr));
    chk({tag, "_out"}, 32'(bus.outstanding), 32'(model_out()));
    chk({tag, "_err"}, 32'(bus.wb_err), 32'(merr));
    clock_and_commit();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1,0,0,1, 5, 5,0, 0,0,32'h0,        0, 32'h0,        32'h0,        0, 0);
    tbl[1]  = mk(1,1,0,0, 0, 5,0, 0,0,32'h0,        1, 32'h0,        32'h0,        1, 0);
    tbl[2]  = mk(1,1,0,0, 0, 5,0, 1,5,32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h0,        1, 0);
    tbl[3]  = mk(0,0,0,0, 0, 5,5, 0,0,32'h0,        0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tbl[4]  = mk(1,0,0,1, 0, 0,0, 1,0,32'h1234,     0, 32'h0,        32'h0,        0, 0);
    tbl[5]  = mk(0,0,0,0, 0, 0,5, 0,0,32'h0,        0, 32'h0,        32'hDEADBEEF, 0, 0);
    tbl[6]  = mk(1,0,0,1, 7, 0,0, 0,0,32'h0,        0, 32'h0,        32'h0,        0, 0);
    tbl[7]  = mk(1,0,0,1, 7, 0,0, 0,0,32'h0,        1, 32'h0,        32'h0,        1, 0);
    tbl[8]  = mk(1,0,0,1, 7, 7,0, 1,7,32'h77,       0, 32'h77,       32'h0,        1, 0);
    tbl[9]  = mk(1,0,1,0, 0, 7,7, 0,0,32'h0,        1, 32'h77,       32'h77,       1, 0);
    tbl[10] = mk(0,0,0,0, 0, 9,0, 1,9,32'hA5A5A5A5, 0, 32'hA5A5A5A5, 32'h0,        1, 0);
    tbl[11] = mk(0,0,0,0, 0, 9,0, 0,0,32'h0,        0, 32'hA5A5A5A5, 32'h0,        1, 1);
    tbl[12] = mk(0,0,0,0, 0, 0,7, 1,7,32'h700,      0, 32'h0,        32'h700,      1, 1);
    tbl[13] = mk(0,0,0,0, 0, 0,7, 0,0,32'h0,        0, 32'h0,        32'h700,      0, 1);

    rst = 1'b1;
    drive(0,0,0,0,0,0,0,0,0,32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: RAW with bypass, x0, WAW + same-cycle re-issue, spurious writeback
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].u1, tbl[i].u2, tbl[i].we, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
            tbl[i].wv, tbl[i].wrd, tbl[i].wdata);
      #2;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_rs1", i), bus.rs1_data, tbl[i].e_rs1);
      chk($sformatf("v%0d_rs2", i), bus.rs2_data, tbl[i].e_rs2);
      chk($sformatf("v%0d_out", i), 32'(bus.outstanding), 32'(tbl[i].e_out));
      chk($sformatf("v%0d_err", i), 32'(bus.wb_err), 32'(tbl[i].e_err));
      clock_and_commit();
    end

    // Mid-cycle async reset with registers busy and wb_err already set
    drive(1,0,0,1, 3, 0,0, 0,0,32'h0); cycle_check("pre_rst_a");
    drive(1,0,0,1, 4, 0,0, 0,0,32'h0); cycle_check("pre_rst_b");
    drive(1,1,0,0, 0, 3,5, 0,0,32'h0);
    #2;
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_out", 32'(bus.outstanding), 32'd0);
    chk("rst_err", 32'(bus.wb_err), 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus.rs1_addr = 5'(a);
      bus.rs2_addr = 5'(31 - a);
      #1;
      chk($sformatf("rst_rs1_%0d", a), bus.rs1_data, 32'd0);
      chk($sformatf("rst_rs2_%0d", 31 - a), bus.rs2_data, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Fill every register, then drain in reverse order
    for (int r = 1; r < 32; r++) begin
      drive(1,0,0,1, 5'(r), 5'(r - 1),0, 0,0,32'h0);
      cycle_check($sformatf("fill_%0d", r));
    end
    drive(0,0,0,0,0,0,0,0,0,32'h0);
    #2;
    chk("fill_out31", 32'(bus.outstanding), 32'd31);
    clock_and_commit();
    for (int r = 31; r >= 1; r--) begin
      drive(1,1,0,0, 0, 5'(r),0, 1,5'(r),32'hC0DE0000 + 32'(r));
      cycle_check($sformatf("drain_%0d", r));
    end
    drive(0,0,0,0,0,0,0,0,0,32'h0);
    #2;
    chk("drain_out0", 32'(bus.outstanding), 32'd0);
    chk("drain_err", 32'(bus.wb_err), 32'd0);
    for (int r = 1; r < 32; r++) begin
      bus.rs1_addr = 5'(r);
      #1;
      chk($sformatf("drain_val_%0d", r), bus.rs1_data, 32'hC0DE0000 + 32'(r));
    end
    clock_and_commit();

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      logic [4:0] busy_list [$];
      logic [4:0] wrd;
      logic       wv;
      for (int i = 1; i < 32; i++) if (mbusy[i]) busy_list.push_back(5'(i));
      wv  = 1'b0;
      wrd = 5'd0;
      if (busy_list.size() != 0 && $urandom_range(0, 99) < 55) begin
        wv  = 1'b1;
        wrd = busy_list[$urandom_range(0, busy_list.size() - 1)];
      end else if ($urandom_range(0, 99) < 3) begin
        wv  = 1'b1;
        wrd = 5'($urandom_range(0, 31));
      end
      drive(1'($urandom_range(0, 99) < 75), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 9)),
            wv, wrd, $urandom);
      cycle_check($sformatf("rnd_%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Integer register file for the RV32 core: 32 entries of XLEN bits (x0 hardwired to zero), two combinational read ports with write-through bypass, one writeback port, and a per-register busy scoreboard. It sits between decode/issue (upstream, source operands) and writeback (downstream, results). The issue stage is stalled until every operand and the destination are free of an outstanding writer.

## Interface
- XLEN, 32, data width of each register entry.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs1_addr  in  5  source 1 index.
- rs2_addr  in  5  source 2 index.
- rs1_data  out  XLEN  source 1 value, combinational.
- rs2_data  out  XLEN  source 2 value, combinational.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_uses_rs1  in  1  instruction reads rs1.
- issue_uses_rs2  in  1  instruction reads rs2.
- issue_rd_we  in  1  instruction will write rd.
- issue_rd  in  5  destination index.
- stall  out  1  issue blocked this cycle, combinational.
- wb_valid  in  1  writeback result valid.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback value.
- outstanding  out  6  number of busy registers, 0..31.
- wb_err  out  1  sticky: writeback hit a non-busy register.

## Operation
- State: regs[1..31] (XLEN each), busy[1..31], outstanding counter, wb_err. Entry 0 has no storage; reads return 0, busy[0] is constant 0.
- Reset (async): all regs = 0, busy = 0, outstanding = 0, wb_err = 0.
- Writeback commit: wb_valid && wb_rd != 0 → regs[wb_rd] <= wb_data, busy[wb_rd] cleared. wb_rd = 0 ignored entirely (no write, no error).
- wb_err set on wb_valid && wb_rd != 0 && !busy[wb_rd]; write still performed; flag holds until rst.
- Read bypass: if wb_valid && wb_rd == rsN_addr && rsN_addr != 0, rsN_data = wb_data; otherwise rsN_data = regs[rsN_addr] (0 for x0).
- Effective busy: busy_eff[i] = busy[i] && !(wb_valid && wb_rd == i).
- Hazard: (uses_rs1 && busy_eff[rs1_addr]) || (uses_rs2 && busy_eff[rs2_addr]) || (rd_we && busy_eff[issue_rd]) — WAW blocked, one pending writer per register.
- stall = issue_valid && hazard. stall is 0 when issue_valid is 0.
- Accept: issue_valid && !stall. On accept with rd_we && issue_rd != 0 → busy[issue_rd] set.
- Same-cycle accept and writeback to same rd: writeback data written, busy ends set (new writer wins).
- outstanding next = outstanding + (set occurs) − (clear of a busy bit occurs); equals popcount(busy) at all times. A writeback to a non-busy register does not decrement. Same-register set+clear nets 0.

## Timing
- Reads, bypass, stall: zero-cycle combinational from inputs and current state.
- Register write, busy update, outstanding, wb_err: visible the cycle after the edge that commits them.
- Issue → writeback minimum distance: 1 cycle (writeback in the cycle after accept is legal; dependents unstall in that same writeback cycle via bypass).
- rst asserted mid-operation clears all state immediately; pending writebacks after rst deassertion target non-busy registers and set wb_err.
- No combinational path from stall back to any input.

## Test plan
- Reset: assert rst mid-cycle → rs1_data/rs2_data = 0 for all addresses, stall = 0, outstanding = 0, wb_err = 0 without waiting for clk.
- RAW: issue rd=5 we; next cycle issue uses_rs1 rs1=5 → stall = 1; cycle with wb_valid rd=5 data 0xDEADBEEF → stall = 0, rs1_data = 0xDEADBEEF (bypass); next cycle regs read 0xDEADBEEF, outstanding 1→0.
- x0: issue rd=0 we, writeback rd=0 data 0x1234 → rs1_data(0) = 0, outstanding stays 0, no stall, wb_err = 0.
- WAW and same-cycle: issue rd=7 (busy); issue rd=7 again → stall; in a cycle with wb rd=7 plus issue rd=7 → accept, busy[7] remains 1, outstanding unchanged at 1.
- Spurious writeback: wb_valid rd=9 data 0xA5A5A5A5 with busy[9]=0 → regs[9] = 0xA5A5A5A5, wb_err = 1 and stays 1, outstanding unchanged.
- Fill: issue rd=1..31 back-to-back → outstanding = 31; writeback all in reverse order → outstanding = 0, each register holds its written value.
